// File: rtl/lmc_pkg.sv
// Shared constants and types for the LMC memory slice.
//   LMC_WORD_W / LMC_ADDR_W / LMC_DEPTH : default word width, address width, depth
//   lmc_ld_state_t                      : program loader states
// The loader is only built when LMC_MEM_LOAD_EN is defined.
package lmc_pkg;

  localparam int LMC_WORD_W = 11;
  localparam int LMC_ADDR_W = 7;
  localparam int LMC_DEPTH  = 100;

  typedef enum logic [1:0] {
    LOAD,
    CLEAR,
    RUN
  } lmc_ld_state_t;

endpackage

// File: rtl/lmc_mem_array.sv
// Word storage for lmc_mem: one synchronous write port, one combinational
// read port. Addresses at or beyond DEPTH read as zero and ignore writes.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   we/waddr/wdata write strobe, address and data
//   raddr/rdata    read address and combinational read data
// Macro LMC_MEM_LOAD_EN: when undefined the storage is zeroed by reset
// (no loader exists to initialise it); when defined contents survive reset.
module lmc_mem_array
  import lmc_pkg::*;
#(
  parameter int DEPTH  = LMC_DEPTH,
  parameter int WIDTH  = LMC_WORD_W,
  parameter int ADDR_W = LMC_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [WIDTH-1:0]  rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic signed [WIDTH-1:0] mem [DEPTH];

`ifdef LMC_MEM_LOAD_EN
  logic unused_reset;
  assign unused_reset = reset;

  always_ff @(posedge clk) begin
    if (we && waddr <= LAST) mem[waddr] <= wdata;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && waddr <= LAST) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  // Read-during-write sees the old word because the array updates at the edge.
  assign rdata = (raddr <= LAST) ? mem[raddr] : '0;

endmodule

// File: rtl/lmc_mem.sv
// Program/data store for the LMC core with optional on-chip program loader.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   addr/data/write_enable/out  core memory interface (combinational read)
//   ld_valid/ld_ready/ld_word/ld_last  loader word stream
//   cpu_hold            core held in reset while high
//   ld_count            words accepted in the current load
// Macro LMC_MEM_LOAD_EN: defined builds the LOAD -> CLEAR -> RUN loader;
// undefined leaves the core free-running and ties loader outputs to zero.
module lmc_mem
  import lmc_pkg::*;
#(
  parameter int DEPTH  = LMC_DEPTH,
  parameter int WIDTH  = LMC_WORD_W,
  parameter int ADDR_W = LMC_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [WIDTH-1:0]  data,
  input  logic                     write_enable,
  output logic signed [WIDTH-1:0]  out,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic signed [WIDTH-1:0]  ld_word,
  input  logic                     ld_last,
  output logic                     cpu_hold,
  output logic [ADDR_W-1:0]        ld_count
);

  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic signed [WIDTH-1:0] wdata;

`ifdef LMC_MEM_LOAD_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  lmc_ld_state_t           state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic                    ld_we;
  logic signed [WIDTH-1:0] ld_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ld_we    = 1'b0;
    ld_wdata = '0;
    unique case (state_q)
      LOAD: begin
        if (ld_valid) begin
          ld_we    = 1'b1;
          ld_wdata = ld_word;
          ptr_d    = ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q + ADDR_W'(1);
          // A full image goes straight to RUN; a short one zero-fills the tail.
          if (ld_last || ptr_q == LAST) state_d = (ptr_q < LAST) ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        ld_we = 1'b1;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: ;
      default: state_d = LOAD;
    endcase
  end

  assign ld_ready = (state_q == LOAD);
  assign cpu_hold = (state_q != RUN);
  assign ld_count = cnt_q;

  // Loader owns the write port whenever it writes; core writes wait for RUN.
  assign we    = ld_we | (write_enable & ~cpu_hold);
  assign waddr = ld_we ? ptr_q : addr;
  assign wdata = ld_we ? ld_wdata : data;
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_word, ld_last};

  assign ld_ready = 1'b0;
  assign cpu_hold = 1'b0;
  assign ld_count = '0;

  assign we    = write_enable;
  assign waddr = addr;
  assign wdata = data;
`endif

  lmc_mem_array #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (out)
  );

endmodule
